// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// Segment patterns are active-low, with bit7=a down to bit1=g and bit0=dp.
package seg7_pkg;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_X     = 8'h91;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71
  };

endpackage

// File: rtl/seg7_scan_driver_hex7seg_dec.sv
// Combinational hex nibble to active-low segment pattern decoder.
// A nibble that matches no table entry (X/Z in simulation) yields SEG_X.
module hex7seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_X;
    for (int i = 0; i < 16; i++) begin
      if (nibble == 4'(i)) seg = SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a one-clock guard per
// slot, leading-zero suppression, per-digit decimal points and global blank.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic                  blank,
  output logic [7:0]            led_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int unsigned PC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PC_W-1:0]       pc;
  logic [IDX_W-1:0]      idx;
  logic [4*DIGITS-1:0]   shadow;
  logic [DIGITS-1:0]     shadow_dp;

  logic                  pc_wrap;
  logic                  idx_wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_sup;
  logic                  zero_above;
  logic [DIGITS-1:0]     drive_sel;
  logic [7:0]            dec_seg;
  logic [7:0]            drive_seg;

  assign pc_wrap  = (pc == PC_LAST);
  assign idx_wrap = (idx == IDX_LAST);

  // Select the active digit; zero_above tracks "this nibble and all above are 0".
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_sup    = 1'b0;
    drive_sel  = '1;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & (shadow[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        cur_nib      = shadow[4*i +: 4];
        cur_dp       = shadow_dp[i];
        cur_sup      = lz_en & (i != 0) & zero_above;
        drive_sel[i] = 1'b0;
      end
    end
  end

  hex7seg_dec u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // A suppressed digit goes dark on a-g but keeps its decimal point.
  always_comb begin
    drive_seg = dec_seg;
    if (cur_sup) drive_seg[SEG_A:SEG_G] = '1;
    drive_seg[SEG_DP] = ~cur_dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      frame_done <= 1'b0;
      led_out    <= SEG_BLANK;
      digit_sel  <= '1;
    end else begin
      pc         <= pc_wrap ? '0 : pc + PC_W'(1);
      frame_done <= pc_wrap & idx_wrap;
      if (pc_wrap) idx <= idx_wrap ? '0 : idx + IDX_W'(1);
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp_in;
      end
      if (blank || pc == '0) begin
        led_out   <= SEG_BLANK;
        digit_sel <= '1;
      end else begin
        led_out   <= drive_seg;
        digit_sel <= drive_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4): directed
// scenarios plus randomized traffic against a cycle-level reference model.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        blank;
  logic [7:0]  led_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .blank      (blank),
    .led_out    (led_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ref_tab [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71
  };

  // Reference model state
  int          m_pc  = 0;
  int          m_idx = 0;
  logic [15:0] m_sh  = '0;
  logic [3:0]  m_dp  = '0;
  logic [7:0]  m_led = 8'hFF;
  logic [3:0]  m_sel = 4'hF;
  logic        m_fd  = 1'b0;

  logic [7:0]  seen [4];
  int          fd_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, update the model from pre-edge state, then compare.
  task automatic step();
    logic [15:0] upper;
    logic [7:0]  pat;
    @(posedge clk);
    if (rst) begin
      m_led = 8'hFF; m_sel = 4'hF; m_fd = 1'b0;
      m_pc = 0; m_idx = 0; m_sh = '0; m_dp = '0;
    end else begin
      if (blank || m_pc == 0) begin
        m_led = 8'hFF;
        m_sel = 4'hF;
      end else begin
        upper = m_sh >> (4 * m_idx);
        pat   = ref_tab[upper[3:0]];
        if (lz_en && m_idx > 0 && upper == 16'h0) pat = 8'hFF;
        if (m_dp[m_idx]) pat = pat & 8'hFE;
        m_led = pat;
        m_sel = 4'(4'hF ^ (4'h1 << m_idx));
      end
      m_fd = (m_pc == SCAN_DIV - 1) && (m_idx == DIGITS - 1);
      if (m_pc == SCAN_DIV - 1) begin
        m_pc  = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_pc = m_pc + 1;
      end
      if (load) begin
        m_sh = value;
        m_dp = dp_in;
      end
    end
    #1;
    check("led_out", 32'(led_out), 32'(m_led));
    check("digit_sel", 32'(digit_sel), 32'(m_sel));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    for (int d = 0; d < 4; d++)
      if (digit_sel == 4'(4'hF ^ (4'h1 << d))) seen[d] = led_out;
    if (frame_done) fd_count++;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value = v; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_frame(input int n);
    for (int d = 0; d < 4; d++) seen[d] = 8'hxx;
    fd_count = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_seen(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                            input logic [7:0] d1, input logic [7:0] d0);
    check({tag, "_d3"}, 32'(seen[3]), 32'(d3));
    check({tag, "_d2"}, 32'(seen[2]), 32'(d2));
    check({tag, "_d1"}, 32'(seen[1]), 32'(d1));
    check({tag, "_d0"}, 32'(seen[0]), 32'(d0));
  endtask

  initial begin
    int bound;
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0; blank = 1'b0;

    // Reset hold and release
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_led", 32'(led_out), 32'h0000_00FF);
      check("rst_sel", 32'(digit_sel), 32'h0000_000F);
    end
    rst = 1'b0;
    step();
    check("guard_sel", 32'(digit_sel), 32'h0000_000F);
    check("guard_led", 32'(led_out), 32'h0000_00FF);
    for (int k = 0; k < 3; k++) begin
      step();
      check("d0_sel", 32'(digit_sel), 32'h0000_000E);
      check("d0_led", 32'(led_out), 32'h0000_0003);
    end

    // Plain decode and frame pulse rate
    do_load(16'h1234, 4'b0000);
    run_frame(16);
    run_frame(16);
    check_seen("v1234", 8'h9F, 8'h25, 8'h0D, 8'h99);
    check("fd_per_16", 32'(fd_count), 32'd1);

    // Leading-zero suppression
    lz_en = 1'b1;
    do_load(16'h0050, 4'b0000);
    run_frame(20);
    check_seen("lz0050", 8'hFF, 8'hFF, 8'h49, 8'h03);
    do_load(16'h0000, 4'b0000);
    run_frame(20);
    check_seen("lz0000", 8'hFF, 8'hFF, 8'hFF, 8'h03);

    // Decimal points, including on a suppressed digit
    lz_en = 1'b0;
    do_load(16'h1234, 4'b0010);
    run_frame(20);
    check("dp_d1", 32'(seen[1]), 32'h0000_000C);
    lz_en = 1'b1;
    do_load(16'h0000, 4'b0010);
    run_frame(20);
    check("dp_sup_d1", 32'(seen[1]), 32'h0000_00FE);

    // Mid-slot load on digit 2
    lz_en = 1'b0;
    do_load(16'h1234, 4'b0000);
    bound = 0;
    while (!(m_idx == 2 && m_pc == 1) && bound < 64) begin
      step();
      bound++;
    end
    check("midload_reach", 32'(bound < 64), 32'd1);
    do_load(16'hFFFF, 4'b0000);
    check("midload_old", 32'(led_out), 32'h0000_0025);
    step();
    check("midload_new", 32'(led_out), 32'h0000_0071);
    check("midload_sel", 32'(digit_sel), 32'h0000_000B);

    // Blank preserves scan phase
    blank = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("blank_led", 32'(led_out), 32'h0000_00FF);
    end
    blank = 1'b0;
    run_frame(8);

    // Reset mid-slot
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_restart_guard", 32'(digit_sel), 32'h0000_000F);
    step();
    check("rst_restart_d0", 32'(digit_sel), 32'h0000_000E);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) value[15:4] = 12'h000;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      blank = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
